// File: rtl/pu_msp430_trace_pkg.sv
// Shared types and constants for the MSP430 instruction-trace recorder.
// Record layout on the read port is {cid, irq, op, pc, cyc}.
package pu_msp430_trace_pkg;

    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        TRC_OFF       = 2'd0,
        TRC_ALL       = 2'd1,
        TRC_IRQ_ONLY  = 2'd2,
        TRC_PC_WINDOW = 2'd3
    } trc_mode_e;

    // Core-independent part of a trace record; the core id is prepended at the top level.
    typedef struct packed {
        logic             irq;
        logic [15:0]      op;
        logic [15:0]      pc;
        logic [CNT_W-1:0] cyc;
    } trc_rec_t;

    localparam logic [3:0] IRQ_NMI   = 4'd14;
    localparam logic [3:0] IRQ_RESET = 4'd15;

endpackage

// File: rtl/pu_msp430_trace_fifo.sv
// Synchronous trace FIFO with flush and optional overwrite-oldest on push when full.
// The head is presented from registered storage and reads as zero while empty.
module pu_msp430_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_ovw,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level,
    output logic [WIDTH-1:0] o_head,
    output logic             o_discard
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_level;
    logic             w_pop;
    logic             w_push;
    logic             w_disc;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = o_empty ? '0 : r_mem[r_rd];

    assign w_pop     = i_pop && !o_empty;
    // A push into a full FIFO with no pop in the same cycle evicts the oldest entry.
    assign w_disc    = i_push && o_full && i_ovw && !w_pop;
    assign w_push    = i_push && (!o_full || i_ovw || w_pop);
    assign o_discard = w_disc && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop || w_disc) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !(w_pop || w_disc)) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pu_msp430_trace.sv
// Multi-core MSP430 instruction-trace recorder: per-core cycle counters, mode filter,
// one pending slot per core, round-robin arbitration into a trace FIFO, drop counter.
module pu_msp430_trace #(
    parameter int NCORES    = 2,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 12,
    parameter int OVERWRITE = 0,
    localparam int CID_W    = (NCORES > 1) ? $clog2(NCORES) : 1,
    localparam int REC_W    = CID_W + 33 + CNT_W
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic [NCORES-1:0]       decode,
    input  logic [16*NCORES-1:0]    ir,
    input  logic [16*NCORES-1:0]    pc,
    input  logic [NCORES-1:0]       irq_detect,
    input  logic [4*NCORES-1:0]     irq_num,
    input  logic [1:0]              trc_mode,
    input  logic [15:0]             pc_lo,
    input  logic [15:0]             pc_hi,
    input  logic                    trc_clear,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [REC_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             drop_cnt
);

    import pu_msp430_trace_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt      [NCORES];
    logic [NCORES-1:0] r_pend_v;
    logic [REC_W-1:0] r_pend_rec [NCORES];
    logic [CID_W-1:0] r_last;
    logic [15:0]      r_drop;

    logic [CNT_W-1:0] w_cyc      [NCORES];
    logic [REC_W-1:0] w_new_rec  [NCORES];
    logic [NCORES-1:0] w_pass;
    logic [NCORES-1:0] w_gnt;
    logic [NCORES-1:0] w_lost;
    logic [CID_W-1:0] w_gnt_idx;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_discard;
    logic [3:0]       w_drop_inc;
    logic [16:0]      w_drop_sum;
    trc_mode_e        w_mode;

    assign w_mode = trc_mode_e'(trc_mode);

    for (genvar c = 0; c < NCORES; c++) begin : g_core
        logic [15:0] w_pc;
        logic [15:0] w_op;
        logic        w_in_win;
        assign w_pc         = pc[16*c +: 16];
        assign w_op         = irq_detect[c] ? {12'b0, irq_num[4*c +: 4]} : ir[16*c +: 16];
        assign w_in_win     = (w_pc >= pc_lo) && (w_pc <= pc_hi);
        assign w_cyc[c]     = (r_cnt[c] == CNT_MAX) ? CNT_MAX : r_cnt[c] + 1'b1;
        assign w_new_rec[c] = {CID_W'(c), irq_detect[c], w_op, w_pc, w_cyc[c]};
        assign w_pass[c]    = decode[c] && !trc_clear &&
                              ((w_mode == TRC_ALL) ||
                               (w_mode == TRC_IRQ_ONLY && irq_detect[c]) ||
                               (w_mode == TRC_PC_WINDOW && w_in_win));
    end

    // A load into a slot that stays occupied this cycle loses the new record.
    assign w_lost = w_pass & r_pend_v & ~w_gnt;

    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_push    = 1'b0;
        for (int k = 1; k <= NCORES; k++) begin
            if (!w_push && r_pend_v[(int'(r_last) + k) % NCORES] &&
                (!w_full || (OVERWRITE != 0))) begin
                w_push    = 1'b1;
                w_gnt_idx = CID_W'((int'(r_last) + k) % NCORES);
                w_gnt[(int'(r_last) + k) % NCORES] = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            for (int c = 0; c < NCORES; c++) begin
                r_cnt[c]      <= '0;
                r_pend_rec[c] <= '0;
            end
            r_pend_v <= '0;
        end else begin
            for (int c = 0; c < NCORES; c++) begin
                r_cnt[c] <= decode[c] ? '0 : w_cyc[c];
                if (trc_clear) begin
                    r_pend_v[c] <= 1'b0;
                end else if (w_pass[c] && (!r_pend_v[c] || w_gnt[c])) begin
                    r_pend_v[c]   <= 1'b1;
                    r_pend_rec[c] <= w_new_rec[c];
                end else if (w_gnt[c]) begin
                    r_pend_v[c] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_drop_inc = {3'b0, w_discard};
        for (int c = 0; c < NCORES; c++) begin
            w_drop_inc = w_drop_inc + {3'b0, w_lost[c]};
        end
        w_drop_sum = {1'b0, r_drop} + {13'b0, w_drop_inc};
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_last <= CID_W'(NCORES - 1);
            r_drop <= '0;
        end else if (trc_clear) begin
            r_last <= CID_W'(NCORES - 1);
            r_drop <= '0;
        end else begin
            if (w_push) begin
                r_last <= w_gnt_idx;
            end
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    pu_msp430_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .i_clk       (mclk),
        .i_rst_n     (puc_rst_n),
        .i_flush     (trc_clear),
        .i_push      (w_push),
        .i_push_data (r_pend_rec[w_gnt_idx]),
        .i_ovw       (OVERWRITE != 0),
        .i_pop       (rd_ready),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (level),
        .o_head      (rd_data),
        .o_discard   (w_discard)
    );

    assign rd_valid = !w_empty;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_pu_msp430_trace.sv
// Bench for pu_msp430_trace: two instances (stop-when-full and overwrite) share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_pu_msp430_trace;

  localparam int NC   = 2;
  localparam int DEP  = 4;
  localparam int CW   = 4;
  localparam int CIDW = 1;
  localparam int RW   = CIDW + 33 + CW;

  logic mclk = 1'b0;
  logic puc_rst_n;
  always #5 mclk = ~mclk;

  logic [NC-1:0]    decode;
  logic [16*NC-1:0] ir;
  logic [16*NC-1:0] pc;
  logic [NC-1:0]    irq_detect;
  logic [4*NC-1:0]  irq_num;
  logic [1:0]       trc_mode;
  logic [15:0]      pc_lo;
  logic [15:0]      pc_hi;
  logic             trc_clear;
  logic             rd_ready;

  logic             o_valid [2];
  logic [RW-1:0]    o_data  [2];
  logic [2:0]       o_level [2];
  logic [15:0]      o_drop  [2];

  pu_msp430_trace #(.NCORES(NC), .DEPTH(DEP), .CNT_W(CW), .OVERWRITE(0)) u_dut0 (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .decode(decode), .ir(ir), .pc(pc),
    .irq_detect(irq_detect), .irq_num(irq_num), .trc_mode(trc_mode),
    .pc_lo(pc_lo), .pc_hi(pc_hi), .trc_clear(trc_clear),
    .rd_valid(o_valid[0]), .rd_ready(rd_ready), .rd_data(o_data[0]),
    .level(o_level[0]), .drop_cnt(o_drop[0])
  );

  pu_msp430_trace #(.NCORES(NC), .DEPTH(DEP), .CNT_W(CW), .OVERWRITE(1)) u_dut1 (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .decode(decode), .ir(ir), .pc(pc),
    .irq_detect(irq_detect), .irq_num(irq_num), .trc_mode(trc_mode),
    .pc_lo(pc_lo), .pc_hi(pc_hi), .trc_clear(trc_clear),
    .rd_valid(o_valid[1]), .rd_ready(rd_ready), .rd_data(o_data[1]),
    .level(o_level[1]), .drop_cnt(o_drop[1])
  );

  // Reference model state, one copy per instance (index 1 = overwrite variant).
  int            m_cnt  [2][NC];
  bit            m_pv   [2][NC];
  logic [RW-1:0] m_prec [2][NC];
  logic [RW-1:0] exp_q  [2][$];
  int            m_drop [2];
  int            m_last [2];

  int n_total;
  int n_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit passes(int c);
    logic [15:0] p;
    p = pc[16*c +: 16];
    case (trc_mode)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return irq_detect[c];
      default: return (p >= pc_lo) && (p <= pc_hi);
    endcase
  endfunction

  function automatic logic [RW-1:0] make_rec(int c, int cyc);
    logic [15:0] op;
    op = irq_detect[c] ? {12'b0, irq_num[4*c +: 4]} : ir[16*c +: 16];
    return {CIDW'(c), irq_detect[c], op, pc[16*c +: 16], CW'(cyc)};
  endfunction

  task automatic model_reset(int m);
    exp_q[m].delete();
    for (int c = 0; c < NC; c++) begin
      m_cnt[m][c]  = 0;
      m_pv[m][c]   = 1'b0;
      m_prec[m][c] = '0;
    end
    m_drop[m] = 0;
    m_last[m] = NC - 1;
  endtask

  task automatic model_step(int m);
    int g;
    int idx;
    int cmax;
    int cyc;
    bit full;
    bit pop;
    cmax = (1 << CW) - 1;
    full = (exp_q[m].size() >= DEP);
    pop  = rd_ready && (exp_q[m].size() > 0);
    g    = -1;
    if (!full || m == 1) begin
      for (int k = 1; k <= NC; k++) begin
        idx = (m_last[m] + k) % NC;
        if (g < 0 && m_pv[m][idx]) g = idx;
      end
    end
    if (trc_clear) begin
      exp_q[m].delete();
      for (int c = 0; c < NC; c++) m_pv[m][c] = 1'b0;
      m_drop[m] = 0;
      m_last[m] = NC - 1;
    end else begin
      if (pop) void'(exp_q[m].pop_front());
      if (g >= 0) begin
        if (full && !pop) begin
          void'(exp_q[m].pop_front());
          m_drop[m]++;
        end
        exp_q[m].push_back(m_prec[m][g]);
        m_last[m] = g;
        m_pv[m][g] = 1'b0;
      end
      for (int c = 0; c < NC; c++) begin
        if (decode[c] && passes(c)) begin
          cyc = (m_cnt[m][c] + 1 > cmax) ? cmax : m_cnt[m][c] + 1;
          if (m_pv[m][c]) begin
            m_drop[m]++;
          end else begin
            m_pv[m][c]   = 1'b1;
            m_prec[m][c] = make_rec(c, cyc);
          end
        end
      end
      if (m_drop[m] > 65535) m_drop[m] = 65535;
    end
    for (int c = 0; c < NC; c++) begin
      if (decode[c]) m_cnt[m][c] = 0;
      else if (m_cnt[m][c] < cmax) m_cnt[m][c]++;
    end
  endtask

  task automatic check_dut(int m);
    logic [RW-1:0] exp_head;
    exp_head = (exp_q[m].size() > 0) ? exp_q[m][0] : '0;
    check($sformatf("rd_valid%0d", m), 64'(o_valid[m]), 64'(exp_q[m].size() > 0));
    check($sformatf("level%0d", m),    64'(o_level[m]), 64'(exp_q[m].size()));
    check($sformatf("drop_cnt%0d", m), 64'(o_drop[m]),  64'(m_drop[m]));
    check($sformatf("rd_data%0d", m),  64'(o_data[m]),  64'(exp_head));
  endtask

  task automatic cycle();
    for (int m = 0; m < 2; m++) begin
      if (!puc_rst_n) model_reset(m);
      else model_step(m);
    end
    @(posedge mclk);
    #1;
    for (int m = 0; m < 2; m++) check_dut(m);
  endtask

  task automatic idle();
    decode     = '0;
    irq_detect = '0;
    trc_clear  = 1'b0;
  endtask

  task automatic dec(int c, logic [15:0] p, logic [15:0] i, bit irqd, logic [3:0] n);
    decode[c]         = 1'b1;
    pc[16*c +: 16]    = p;
    ir[16*c +: 16]    = i;
    irq_detect[c]     = irqd;
    irq_num[4*c +: 4] = n;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    puc_rst_n = 1'b0;
    idle();
    ir = '0; pc = '0; irq_num = '0;
    rd_ready = 1'b0;
    trc_mode = 2'd1;
    pc_lo = 16'h0000;
    pc_hi = 16'hFFFF;
    for (int m = 0; m < 2; m++) model_reset(m);
    @(negedge mclk);
    repeat (3) cycle();
    puc_rst_n = 1'b1;

    // ALL mode, core 0 only; the long lead-in saturates the first cyc value.
    rd_ready = 1'b1;
    repeat (20) cycle();
    for (int t = 0; t < 10; t++) begin
      idle();
      if (t == 0) dec(0, 16'h1000, 16'h4303, 1'b0, 4'd0);
      if (t == 3) dec(0, 16'h1002, 16'h4303, 1'b0, 4'd0);
      if (t == 4) dec(0, 16'h1004, 16'h4303, 1'b0, 4'd0);
      cycle();
    end

    trc_mode = 2'd2;
    for (int t = 0; t < 8; t++) begin
      idle();
      if (t == 0) dec(0, 16'h2000, 16'h1234, 1'b0, 4'd0);
      if (t == 2) dec(0, 16'h2002, 16'h1234, 1'b1, 4'd9);
      if (t == 4) dec(0, 16'h2004, 16'h1234, 1'b0, 4'd0);
      cycle();
    end

    trc_mode = 2'd3;
    pc_lo = 16'hF000;
    pc_hi = 16'hF00F;
    for (int t = 0; t < 8; t++) begin
      idle();
      if (t == 0) dec(0, 16'hEFFE, 16'h4303, 1'b0, 4'd0);
      if (t == 1) dec(0, 16'hF000, 16'h4303, 1'b0, 4'd0);
      if (t == 2) dec(0, 16'hF00F, 16'h4303, 1'b0, 4'd0);
      if (t == 3) dec(0, 16'hF010, 16'h4303, 1'b0, 4'd0);
      cycle();
    end

    // Both cores decode every cycle: alternating grants and pending-slot drops.
    trc_mode = 2'd1;
    for (int t = 0; t < 10; t++) begin
      idle();
      if (t < 4) begin
        dec(0, 16'h3000 + 16'(2*t), 16'hA000 + 16'(t), 1'b0, 4'd0);
        dec(1, 16'h4000 + 16'(2*t), 16'hB000 + 16'(t), 1'b0, 4'd0);
      end
      cycle();
    end

    // Fill the small FIFO with no consumer, then drain.
    idle();
    trc_clear = 1'b1;
    cycle();
    rd_ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      idle();
      if (t < 6) dec(0, 16'h5000 + 16'(2*t), 16'hC000 + 16'(t), 1'b0, 4'd0);
      cycle();
    end
    idle();
    trc_clear = 1'b1;
    cycle();
    idle();
    rd_ready = 1'b1;
    repeat (4) cycle();

    // Reset asserted in the middle of a burst.
    rd_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      idle();
      dec(t % NC, 16'h6000 + 16'(t), 16'hD000, 1'b0, 4'd0);
      cycle();
    end
    idle();
    puc_rst_n = 1'b0;
    repeat (2) cycle();
    puc_rst_n = 1'b1;
    rd_ready = 1'b1;
    repeat (3) cycle();
    dec(1, 16'h7000, 16'hE000, 1'b0, 4'd0);
    cycle();
    idle();
    repeat (4) cycle();

    pc_lo = 16'hF004;
    pc_hi = 16'hF00B;
    for (int t = 0; t < 2000; t++) begin
      idle();
      if (t % 100 == 0) trc_mode = 2'($urandom_range(0, 3));
      if ((t / 150) % 3 == 2) rd_ready = ($urandom_range(0, 7) == 0);
      else rd_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          dec(c,
              ($urandom_range(0, 1) == 0) ? {12'hF00, 4'($urandom_range(0, 15))} : 16'($urandom),
              16'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
        end
      end
      if ($urandom_range(0, 63) == 0) trc_clear = 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        puc_rst_n = 1'b0;
        cycle();
        puc_rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pu_msp430_trace.md
# pu_msp430_trace

Parametrised, synthesizable instruction-trace recorder for one or more MSP430 cores. Taps each core's decode strobe, instruction register, PC and interrupt signals. Builds one record per decoded instruction: core id, opcode or IRQ number, PC, and cycle count. Records pass through a runtime filter and round-robin arbitration into a trace FIFO, which debug logic or a bench drains through a valid/ready port.

## Interface
Parameters:
- NCORES, 2: number of traced cores, 1..4.
- DEPTH, 16: trace FIFO entries, power of two, 4..256.
- CNT_W, 12: cycle-count field width; saturating.
- OVERWRITE, 0: 0 = stop capturing when full; 1 = overwrite the oldest entry.

Ports:
- mclk  in  1  core clock; all state on rising edge.
- puc_rst_n  in  1  reset, asynchronous assert, active-low.
- decode  in  NCORES  per-core instruction-decode strobe.
- ir  in  16*NCORES  per-core instruction register, core c at [16c+:16].
- pc  in  16*NCORES  per-core program counter.
- irq_detect  in  NCORES  per-core: the decode is an interrupt entry.
- irq_num  in  4*NCORES  per-core IRQ number (14 = NMI, 15 = RESET).
- trc_mode  in  2  0 OFF, 1 ALL, 2 IRQ_ONLY, 3 PC_WINDOW.
- pc_lo, pc_hi  in  16 each  inclusive PC window, used in mode 3.
- trc_clear  in  1  synchronous flush.
- rd_valid  out  1  FIFO head valid.
- rd_ready  in  1  consumer accepts the head.
- rd_data  out  REC_W  head record: {cid, irq, op[15:0], pc[15:0], cyc[CNT_W-1:0]}.
  - REC_W = CID_W + 33 + CNT_W.
  - CID_W = max(1, clog2(NCORES)).
  - op = {12'b0, irq_num} when irq = 1.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- drop_cnt  out  16  records lost; saturates at 16'hFFFF.

## Operation
- Cycle counter, one per core, always running regardless of mode:
  - On a decode cycle: the captured value is min(cnt+1, 2^CNT_W-1), and cnt <= 0.
  - Otherwise: cnt <= cnt+1, saturating.
  - cyc is the number of mclk cycles since that core's previous decode.
- Filter, evaluated on a decode cycle:
  - Mode 0: nothing passes.
  - Mode 1: everything passes.
  - Mode 2: passes only if irq_detect = 1.
  - Mode 3: passes only if pc_lo <= pc <= pc_hi, unsigned.
- Pending slot, one per core:
  - A filtered decode loads the slot.
  - If the slot is still full and is not granted in that same cycle, the new record is dropped and drop_cnt increments.
  - A grant and a new load in the same cycle is not a drop.
- Arbiter: round-robin among full pending slots, one grant per cycle. Priority starts after the last granted core; after reset, core 0 has top priority.
- FIFO full, OVERWRITE = 0: no grant is issued; pending slots hold; further decodes drop.
- FIFO full, OVERWRITE = 1: the grant writes, the oldest entry is discarded, and drop_cnt increments. If rd_ready is high in the same cycle, that pop is the discarded entry and no drop is counted.
- Simultaneous read and write: level is unchanged, pointers wrap modulo DEPTH.
- trc_clear: empties the FIFO and all pending slots, clears drop_cnt, and resets arbiter priority. Cycle counters are unaffected. A decode in the same cycle as trc_clear is discarded.
- Reset: rd_valid = 0, level = 0, drop_cnt = 0, rd_data = 0, all pending slots empty, all counters 0, arbiter priority on core 0.

## Timing
- Decode at cycle t: the pending slot is full at t+1, and the record is written at the end of t+1 if granted. rd_valid rises at t+2 when there is no contention and the FIFO was empty.
- rd_data is registered output from the FIFO head. A pop on rd_valid & rd_ready presents the next entry in the following cycle.
- rd_valid never depends combinationally on rd_ready.

## Structure
- Package pu_msp430_trace_pkg holds:
  - the trc_mode_e enum: OFF, ALL, IRQ_ONLY, PC_WINDOW;
  - the trc_rec_t packed struct, parametrised through a localparam CNT_W default;
  - the NMI/RESET IRQ number constants.
- Sub-module pu_msp430_trace_fifo: synchronous FIFO with DEPTH and WIDTH parameters, push/pop, full/empty, level, force-push-overwrite and flush inputs.
- Top level: per-core counters, filter, pending slots, arbiter, drop counter.

## Test plan
- NCORES = 1, mode ALL. Core 0 decodes at cycles 10, 13 and 14 with pc 0x1000, 0x1002, 0x1004 and ir 0x4303. Expect three records in order with cyc 3 and 1 for the second and third, and rd_valid at cycle 12.
- Mode IRQ_ONLY. Decodes with irq_detect = 0, 1 (irq_num = 9), 0. Expect exactly one record with irq = 1, op = 0x0009, and drop_cnt = 0.
- Mode PC_WINDOW with pc_lo = 0xF000, pc_hi = 0xF00F. Decode PCs 0xEFFE, 0xF000, 0xF00F, 0xF010. Expect records only for 0xF000 and 0xF00F.
- NCORES = 2. Both cores decode every cycle for 4 cycles with rd_ready = 1. Expect grants to alternate c0, c1, c0, c1, and drop_cnt to count the overflowed pending loads.
- DEPTH = 4, rd_ready = 0, 6 decodes. With OVERWRITE = 0: level = 4, the head is the first record, drop_cnt = 1 (one record still held in pending). With OVERWRITE = 1: the head is the third record and drop_cnt = 2.
- Assert puc_rst_n low mid-burst, and separately pulse trc_clear. Expect level = 0, rd_valid = 0 and drop_cnt = 0 in the next cycle. After reset release, the first record's cyc counts from reset release.
